// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Program-counter register and instruction fetch sequencer. The block
//   requests the word at pc from instruction memory and waits for the
//   memory's ready handshake. It then holds the instruction for decode until
//   the core accepts it. An aligned accepted target starts the next fetch.
//   A misaligned accepted target sets a sticky flag and parks the block in
//   HALT until reset. Each accepted advance increments the retired counter.
//
// Parameters
//   RESET_PC    PC loaded on reset (word aligned)
//   CNT_W       width of the retired-instruction counter
//
// Ports
//   clk          i  system clock, rising edge
//   reset        i  asynchronous active-high reset
//   next_pc      i  next PC, sampled only on an accepted advance in HOLD
//   advance      i  core consumed the current instruction
//   imem_req     o  fetch request (FETCH state, suppressed during reset)
//   imem_addr    o  fetch word address, always equal to pc
//   imem_ready   i  memory accepts the request / returns data this cycle
//   imem_rdata   i  instruction word, valid with imem_req && imem_ready
//   pc           o  address of the instruction being fetched or held
//   instr        o  held instruction word
//   instr_valid  o  instr belongs to pc and may be executed
//   misalign     o  sticky: an accepted target had next_pc[1:0] != 0
//   retired      o  count of accepted advances (wraps)
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      next_pc,
   input  logic             advance,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ready,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      pc,
   output logic [31:0]      instr,
   output logic             instr_valid,
   output logic             misalign,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      HALT  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      instr_q, instr_d;
   logic             valid_q, valid_d;
   logic             mis_q, mis_d;
   logic [CNT_W-1:0] ret_q, ret_d;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         mis_q   <= mis_d;
         ret_q   <= ret_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      mis_d   = mis_q;
      ret_d   = ret_q;

      unique case (state_q)
         FETCH: begin
            // advance is deliberately not looked at here
            if (imem_ready) begin
               instr_d = imem_rdata;
               valid_d = 1'b1;
               state_d = HOLD;
            end
         end

         HOLD: begin
            if (advance) begin
               valid_d = 1'b0;
               ret_d   = ret_q + CNT_ONE;
               if (next_pc[1:0] == 2'b00) begin
                  pc_d    = next_pc;
                  state_d = FETCH;
               end else begin
                  // pc keeps the last good address for post-mortem
                  mis_d   = 1'b1;
                  state_d = HALT;
               end
            end
         end

         HALT: begin
            valid_d = 1'b0;
         end

         default: begin
            state_d = FETCH;
         end
      endcase
   end

   // The reset state is FETCH. The request is masked while reset is held,
   // so no handshake is offered until reset is released.
   assign imem_req    = (state_q == FETCH) && !reset;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign misalign    = mis_q;
   assign retired     = ret_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   next_pc;
   logic          advance;
   logic          imem_req;
   logic [31:0]   imem_addr;
   logic          imem_ready;
   logic [31:0]   imem_rdata;
   logic [31:0]   pc;
   logic [31:0]   instr;
   logic          instr_valid;
   logic          misalign;
   logic [CW-1:0] retired;

   int checks   = 0;
   int failures = 0;

   fetch_unit #(.RESET_PC(32'h0000_3000), .CNT_W(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .next_pc     (next_pc),
      .advance     (advance),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .pc          (pc),
      .instr       (instr),
      .instr_valid (instr_valid),
      .misalign    (misalign),
      .retired     (retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          adv;
      logic [31:0]   np;
      logic          rdy;
      logic [31:0]   rd;
      logic          e_req;
      logic [31:0]   e_pc;
      logic          e_valid;
      logic [31:0]   e_instr;
      logic          e_mis;
      logic [CW-1:0] e_ret;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_pc,
                          input logic e_valid, input logic [31:0] e_instr,
                          input logic e_mis, input logic [CW-1:0] e_ret);
      chk({tag, ".imem_req"},    {31'd0, imem_req},    {31'd0, e_req});
      chk({tag, ".pc"},          pc,                   e_pc);
      chk({tag, ".imem_addr"},   imem_addr,            e_pc);
      chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, e_valid});
      chk({tag, ".instr"},       instr,                e_instr);
      chk({tag, ".misalign"},    {31'd0, misalign},    {31'd0, e_mis});
      chk({tag, ".retired"},     {28'd0, retired},     {28'd0, e_ret});
   endtask

   task automatic drive(input logic adv, input logic [31:0] np, input logic rdy, input logic [31:0] rd);
      advance    = adv;
      next_pc    = np;
      imem_ready = rdy;
      imem_rdata = rd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [CW-1:0] exp_ret;
      logic [31:0]   exp_pc;

      //          adv  next_pc       rdy  rdata         req  pc            vld  instr         mis  ret
      vecs[0]  = '{0, 32'h0,         1, 32'h3C01_1234, 0, 32'h0000_3000, 1, 32'h3C01_1234, 0, 4'd0};
      vecs[1]  = '{1, 32'h0000_3004, 0, 32'h0,         1, 32'h0000_3004, 0, 32'h3C01_1234, 0, 4'd1};
      vecs[2]  = '{0, 32'h0,         0, 32'hBAD0_0001, 1, 32'h0000_3004, 0, 32'h3C01_1234, 0, 4'd1};
      vecs[3]  = '{1, 32'h0000_3006, 0, 32'hBAD0_0002, 1, 32'h0000_3004, 0, 32'h3C01_1234, 0, 4'd1};
      vecs[4]  = '{0, 32'h0,         0, 32'hBAD0_0003, 1, 32'h0000_3004, 0, 32'h3C01_1234, 0, 4'd1};
      vecs[5]  = '{0, 32'h0,         1, 32'hAAAA_0001, 0, 32'h0000_3004, 1, 32'hAAAA_0001, 0, 4'd1};
      vecs[6]  = '{0, 32'h0,         1, 32'hDEAD_BEEF, 0, 32'h0000_3004, 1, 32'hAAAA_0001, 0, 4'd1};
      vecs[7]  = '{1, 32'h0000_2FF0, 0, 32'h0,         1, 32'h0000_2FF0, 0, 32'hAAAA_0001, 0, 4'd2};
      vecs[8]  = '{0, 32'h0,         1, 32'h1111_2222, 0, 32'h0000_2FF0, 1, 32'h1111_2222, 0, 4'd2};
      vecs[9]  = '{1, 32'hFFFF_FFFC, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h1111_2222, 0, 4'd3};
      vecs[10] = '{0, 32'h0,         1, 32'h5555_6666, 0, 32'hFFFF_FFFC, 1, 32'h5555_6666, 0, 4'd3};
      vecs[11] = '{1, 32'h0000_3010, 0, 32'h0,         1, 32'h0000_3010, 0, 32'h5555_6666, 0, 4'd4};
      vecs[12] = '{0, 32'h0,         1, 32'h7777_8888, 0, 32'h0000_3010, 1, 32'h7777_8888, 0, 4'd4};
      vecs[13] = '{1, 32'h0000_3006, 1, 32'h9999_0000, 0, 32'h0000_3010, 0, 32'h7777_8888, 1, 4'd5};

      reset = 1'b1;
      drive(0, 32'h0, 0, 32'h0);
      #1;
      chk_all("reset_held", 1'b0, 32'h0000_3000, 1'b0, 32'h0, 1'b0, 4'd0);
      step();
      step();
      reset = 1'b0;
      #1;
      chk_all("reset_release", 1'b1, 32'h0000_3000, 1'b0, 32'h0, 1'b0, 4'd0);

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].adv, vecs[i].np, vecs[i].rdy, vecs[i].rd);
         step();
         chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_pc, vecs[i].e_valid,
                 vecs[i].e_instr, vecs[i].e_mis, vecs[i].e_ret);
      end

      // HALT is sticky: memory ready and advance pulses change nothing
      for (int c = 0; c < 20; c++) begin
         drive(c[0], 32'h0000_4000, 1'b1, 32'h1234_0000 + c);
         step();
         chk_all($sformatf("halt%0d", c), 1'b0, 32'h0000_3010, 1'b0, 32'h7777_8888, 1'b1, 4'd5);
      end

      // Reset mid-fetch at pc 3010 with memory stalled
      reset = 1'b1;
      #1;
      reset = 1'b0;
      drive(0, 32'h0, 1, 32'h0101_0101);
      step();
      drive(1, 32'h0000_3010, 0, 32'h0);
      step();
      drive(0, 32'h0, 0, 32'h0);
      step();
      chk_all("pre_reset_fetch", 1'b1, 32'h0000_3010, 1'b0, 32'h0101_0101, 1'b0, 4'd1);
      #2;
      reset = 1'b1;
      #1;
      chk_all("async_reset", 1'b0, 32'h0000_3000, 1'b0, 32'h0, 1'b0, 4'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_all("post_reset", 1'b1, 32'h0000_3000, 1'b0, 32'h0, 1'b0, 4'd0);
      drive(0, 32'h0, 1, 32'h0F0F_0F0F);
      step();
      chk_all("refetch", 1'b0, 32'h0000_3000, 1'b1, 32'h0F0F_0F0F, 1'b0, 4'd0);

      // Counter wrap: advance stays high through FETCH and must not count there
      exp_ret = '0;
      exp_pc  = 32'h0000_3000;
      for (int k = 0; k < 16; k++) begin
         exp_pc  = exp_pc + 32'd4;
         exp_ret = exp_ret + 4'd1;
         drive(1, exp_pc, 0, 32'h0);
         step();
         chk($sformatf("wrap%0d.retired", k), {28'd0, retired}, {28'd0, exp_ret});
         chk($sformatf("wrap%0d.pc", k), pc, exp_pc);
         drive(1, 32'h0000_0002, 0, 32'h0);
         step();
         chk($sformatf("wrap%0d.stall_ret", k), {28'd0, retired}, {28'd0, exp_ret});
         drive(1, 32'h0000_0002, 1, 32'hC0DE_0000 + k);
         step();
         chk($sformatf("wrap%0d.fetch_ret", k), {28'd0, retired}, {28'd0, exp_ret});
         chk($sformatf("wrap%0d.instr", k), instr, 32'hC0DE_0000 + k);
      end
      chk("wrap_final", {28'd0, retired}, 32'd0);
      chk("wrap_misalign", {31'd0, misalign}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
